regfile_mp: RTL and testbench

- Parametrised multi-port successor to the single-write, dual-read register file.
- Adds configurable read/write port counts, optional write-to-read bypass, and a per-register pending scoreboard for hazard detection.
- Serves as the architectural integer register file between decode (read, issue) and write-back in the pipelined RV32I core.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// Imported by the storage top level and by the pending-bit scoreboard.
package regfile_pkg;

  // Write-port arbitration order on a same-address collision.
  typedef enum logic {
    HIGH_INDEX_WINS = 1'b0
  } port_prio_e;

  localparam port_prio_e WR_PRIO   = HIGH_INDEX_WINS;
  localparam bit         REG_RESET = 1'b0;

  // Address width; a single-entry file still needs one address bit.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, write-back clears, flush wipes.
// Also produces the per-read-port busy view, including the bypass override.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = calc_aw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_addr,
  input  logic                    flush,
  input  logic [DEPTH-1:0]        wr_clr,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  input  logic [NRD-1:0]          rd_hit,
  output logic [NRD-1:0]          rd_busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic             iss_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
  endfunction

  assign iss_ok = iss_valid && !flush && addr_ok(iss_addr);

  // Set after clear: a same-cycle issue is a newer producer still in flight.
  always_comb begin
    pend_nxt = pend & ~wr_clr;
    if (iss_ok) pend_nxt[iss_addr] = 1'b1;
    if (flush) pend_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= pend_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic busy;
    always_comb begin
      busy = 1'b0;
      if (addr_ok(rd_addr[i])) begin
        if (BYPASS && rd_hit[i]) busy = iss_ok && (iss_addr == rd_addr[i]);
        else                     busy = pend[rd_addr[i]];
      end
    end
    assign rd_busy[i] = busy;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port architectural register file: storage, write arbitration,
// same-cycle read bypass and write-collision detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = calc_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_dout,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_din,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  output logic                 wr_conflict
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [NRD-1:0][AW-1:0]      ra;
  logic [NWR-1:0][AW-1:0]      wa;
  logic [NWR-1:0][WIDTH-1:0]   wd;
  logic [NWR-1:0]              wv;
  logic [DEPTH-1:0]            wr_clr;
  logic [NRD-1:0]              rd_hit;
  logic                        conflict_nxt;

  assign ra = rd_addr;
  assign wa = wr_addr;
  assign wd = wr_din;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    wv     = '0;
    wr_clr = '0;
    for (int j = 0; j < NWR; j++) begin
      wv[j] = we[j] && addr_ok(wa[j]);
      if (wv[j]) wr_clr[wa[j]] = 1'b1;
    end
  end

  // Only writes that would really land count; address 0 never flags.
  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < NWR; i++)
      for (int j = i + 1; j < NWR; j++)
        if (wv[i] && wv[j] && (wa[i] == wa[j]) && (wa[i] != '0))
          conflict_nxt = 1'b1;
  end

  // Ascending port loop: the last non-blocking write (highest index) wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem         <= {(DEPTH*WIDTH){REG_RESET}};
      wr_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wv[j]) mem[wa[j]] <= wd[j];
      wr_conflict <= conflict_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic             hit;
    logic [WIDTH-1:0] byp;
    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NWR; j++)
        if (wv[j] && (wa[j] == ra[i])) begin
          hit = 1'b1;
          byp = wd[j];
        end
    end
    assign rd_hit[i] = hit;
    assign rd_dout[i*WIDTH +: WIDTH] = !addr_ok(ra[i])  ? '0  :
                                       (BYPASS && hit) ? byp : mem[ra[i]];
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NRD      (NRD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .wr_clr    (wr_clr),
    .rd_addr   (ra),
    .rd_hit    (rd_hit),
    .rd_busy   (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: a BYPASS=1 and a BYPASS=0 copy
// share the stimulus; expectations are queued and checked at the falling edge.
module tb_regfile_mp;
  localparam int W  = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*AW-1:0]  rd_addr;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*W-1:0]   wr_din;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic [NR*W-1:0]   a_dout, b_dout;
  logic [NR-1:0]     a_busy, b_busy;
  logic              a_conf, b_conf;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(a_dout), .rd_busy(a_busy),
    .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .flush(flush), .wr_conflict(a_conf)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(b_dout), .rd_busy(b_busy),
    .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .flush(flush), .wr_conflict(b_conf)
  );

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [W-1:0] exp;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  // Observation points: 0/1 A dout, 2/3 A busy, 4 A conflict, 5 B dout0, 6 B busy0, 7 B conflict
  function automatic logic [W-1:0] act(input int sel);
    case (sel)
      0: return a_dout[W-1:0];
      1: return a_dout[2*W-1:W];
      2: return {{(W-1){1'b0}}, a_busy[0]};
      3: return {{(W-1){1'b0}}, a_busy[1]};
      4: return {{(W-1){1'b0}}, a_conf};
      5: return b_dout[W-1:0];
      6: return {{(W-1){1'b0}}, b_busy[0]};
      7: return {{(W-1){1'b0}}, b_conf};
      default: return 'x;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [W-1:0] got;
      e   = q.pop_front();
      got = act(e.sel);
      checks++;
      if (e.cyc != cyc || got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, got, e.exp, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    we        = '0;
    iss_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic chk(input string n, input int sel, input logic [W-1:0] v);
    exp_t e;
    e = '{cyc, n, sel, v};
    q.push_back(e);
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    we[p]                = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_din[p*W +: W]     = d;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic iss(input logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_addr  = a;
  endtask

  initial begin
    rd_addr = '0; we = '0; wr_addr = '0; wr_din = '0;
    iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;

    // reset state
    step(); rd(5, 0);
    chk("rst_dout", 0, 32'h0); chk("rst_busy", 2, 32'h0); chk("rst_conf", 4, 32'h0);

    step(); rst = 1'b1; wr(0, 5, 32'hDEADBEEF); rd(5, 0);
    chk("byp_r5", 0, 32'hDEADBEEF); chk("nobyp_r5", 5, 32'h0);
    step(); rd(5, 0);
    chk("stored_r5_a", 0, 32'hDEADBEEF); chk("stored_r5_b", 5, 32'hDEADBEEF);

    // asynchronous reset mid-cycle
    step(); rd(5, 0); #1 rst = 1'b0;
    chk("async_rst_a", 0, 32'h0); chk("async_rst_b", 5, 32'h0); chk("async_rst_conf", 4, 32'h0);

    // dual-write collision
    step(); rst = 1'b1; wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(7, 0);
    chk("coll_byp", 0, 32'h22); chk("coll_conf_pre", 4, 32'h0);
    step(); rd(7, 0);
    chk("coll_r7_a", 0, 32'h22); chk("coll_r7_b", 5, 32'h22);
    chk("coll_conf_a", 4, 32'h1); chk("coll_conf_b", 7, 32'h1);
    step(); rd(7, 0);
    chk("coll_conf_drop", 4, 32'h0);

    // bypass
    step(); wr(0, 3, 32'h1234); rd(3, 3);
    chk("byp_p0", 0, 32'h1234); chk("byp_p1", 1, 32'h1234); chk("nobyp_old", 5, 32'h0);
    step(); rd(3, 0);
    chk("r3_a", 0, 32'h1234); chk("r3_b", 5, 32'h1234);

    // scoreboard set/clear
    step(); iss(9); rd(9, 0);
    chk("sb_pre_issue", 2, 32'h0);
    step(); wr(1, 9, 32'h99); iss(9); rd(9, 0);
    chk("sb_set_wins_a", 2, 32'h1); chk("sb_set_wins_b", 6, 32'h1); chk("sb_byp_data", 0, 32'h99);
    step(); wr(0, 9, 32'hAA); rd(9, 0);
    chk("sb_wr_byp_a", 2, 32'h0); chk("sb_wr_nobyp_b", 6, 32'h1);
    chk("sb_data_a", 0, 32'hAA); chk("sb_data_b", 5, 32'h99);
    step(); rd(9, 0);
    chk("sb_clear_a", 2, 32'h0); chk("sb_clear_b", 6, 32'h0); chk("sb_r9", 0, 32'hAA);

    // flush
    step(); iss(1);
    step(); iss(2); rd(1, 0); chk("fl_r1_busy", 2, 32'h1);
    step(); iss(4); rd(2, 0); chk("fl_r2_busy", 2, 32'h1);
    step(); flush = 1'b1; iss(6); rd(4, 6);
    chk("fl_r4_pre", 2, 32'h1); chk("fl_r6_pre", 3, 32'h0);
    step(); rd(1, 2);
    chk("fl_r1", 2, 32'h0); chk("fl_r2", 3, 32'h0); chk("fl_r1_b", 6, 32'h0);
    step(); rd(4, 6);
    chk("fl_r4", 2, 32'h0); chk("fl_r6", 3, 32'h0); chk("fl_r4_b", 6, 32'h0);

    // zero register
    step(); wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hFFFFFFFF); iss(0); rd(0, 0);
    chk("z_dout_p0", 0, 32'h0); chk("z_dout_p1", 1, 32'h0);
    chk("z_busy", 2, 32'h0); chk("z_dout_b", 5, 32'h0);
    step(); rd(0, 0);
    chk("z_after", 0, 32'h0); chk("z_busy_after", 2, 32'h0);
    chk("z_conf_a", 4, 32'h0); chk("z_conf_b", 7, 32'h0); chk("z_after_b", 5, 32'h0);

    repeat (3) step();
    if (q.size() != 0) begin
      $display("FAIL unchecked_expectations: got %0d pending expected 0", q.size());
      checks += q.size();
      errors += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
